block_memory: RTL

Backing main-memory model sitting directly downstream of the direct-mapped processor cache, on its memory-side port. Serves block-fill reads (one 32-bit, 4-byte block per request) and single-byte writes over a 256-byte array, with parameterised fixed latencies and a return-to-zero request/ready handshake. Used as the cache's memory partner in system simulation and on the FPGA.

---
 rtl/block_memory.sv | 123 ++++++++++++
 1 files changed

// File: rtl/block_memory.sv
// Backing main memory for the direct-mapped cache: 4-byte block reads and
// single-byte writes over a 256-byte array, fixed latencies, RTZ handshake.
module block_memory #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MRead_request,
  input  logic        MWrite_request,
  input  logic [7:0]  MAddress,
  input  logic [7:0]  MWrite_data,
  output logic        MRead_ready,
  output logic [31:0] MRead_data,
  output logic        MWrite_done
);

  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RBUSY, WBUSY, RELEASE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last, last_nxt;
  logic       ready_nxt, done_nxt;
  logic       accept_rd, accept_wr, rd_fire, wr_fire;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] mem [256];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    case (state)
      IDLE: begin
        // Read has priority; a concurrent write simply stays pending.
        if (MRead_request) begin
          accept_rd = 1'b1;
          cnt_nxt   = RD_LOAD;
          last_nxt  = 1'b0;
          state_nxt = RBUSY;
        end else if (MWrite_request) begin
          accept_wr = 1'b1;
          cnt_nxt   = WR_LOAD;
          last_nxt  = 1'b1;
          state_nxt = WBUSY;
        end
      end
      RBUSY: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          rd_fire   = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = RELEASE;
        end
      end
      WBUSY: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          wr_fire   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Only the request just served must return to zero.
        if ((last == 1'b0 && !MRead_request) || (last == 1'b1 && !MWrite_request))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      last        <= 1'b0;
      MRead_ready <= 1'b0;
      MWrite_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      MRead_ready <= ready_nxt;
      MWrite_done <= done_nxt;
    end
  end

  // Latched operands: later address/data changes cannot affect an accepted op.
  always_ff @(posedge clk) begin
    if (accept_rd)
      addr_q <= {MAddress[7:2], 2'b00};
    else if (accept_wr)
      addr_q <= MAddress;
    if (accept_wr)
      wdata_q <= MWrite_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MRead_data <= 32'd0;
      for (int i = 0; i < 256; i++)
        mem[i] <= 8'(i);
    end else begin
      if (rd_fire)
        MRead_data <= {mem[{addr_q[7:2], 2'b11}], mem[{addr_q[7:2], 2'b10}],
                       mem[{addr_q[7:2], 2'b01}], mem[{addr_q[7:2], 2'b00}]};
      if (wr_fire)
        mem[addr_q] <= wdata_q;
    end
  end

endmodule
